arm_fetch_stage: RTL and testbench
==================================

# arm_fetch_stage

Instruction-fetch stage and IF/ID register for `Pipeline_ARM`; it sits directly upstream of decode and produces `InstrD`. It holds the fetch PC, issues pipelined requests to a variable-latency instruction memory, buffers returned words in a 2-entry queue, and presents one instruction per cycle to decode. It honours decode stall/flush and execute-stage branch redirects, discarding in-flight responses from the wrong path.

## Interface
- `RESET_PC`, 32'h0000_0000: fetch address after reset.
- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-high.
- `imem_req` output 1: request valid; combinational from registered state.
- `imem_addr` output 32: word-aligned fetch address (`fetch_pc`).
- `imem_gnt` input 1: request accepted when `imem_req && imem_gnt`.
- `imem_rvalid` input 1: response valid; responses return in request order, ≥1 cycle after grant.
- `imem_rdata` input 32: instruction word, valid with `imem_rvalid`.
- `StallD` input 1: decode cannot accept; hold IF/ID register.
- `FlushD` input 1: invalidate IF/ID register.
- `BranchTakenE` input 1: redirect fetch.
- `BranchTargetE` input 32: redirect target (ALU result of execute).
- `InstrD` output 32: instruction to decode.
- `PCPlus8D` output 32: PC of `InstrD` + 8 (ARM PC-read semantics).
- `ValidD` output 1: `InstrD` holds a real instruction.

## Operation
- State: `fetch_pc`, 2-entry FIFO of {pc, instr} (`count` 0..2), `outstanding` 0..2, `drop_cnt` 0..2, IF/ID register {InstrD, PCPlus8D, ValidD}.
- Issue: `imem_req = !reset && !BranchTakenE && (count + outstanding < 2)`. On grant: `fetch_pc += 4`, `outstanding += 1`.
- Response: `outstanding -= 1` on `imem_rvalid` (net 0 if grant in same cycle). If `drop_cnt != 0`: discard word, `drop_cnt -= 1`. Otherwise word tagged with pc of its request (tracked by a 2-entry in-order pc tag queue or equivalent).
- Decode load (when `!StallD`): source priority FIFO head (pop), else live response (bypass), else bubble. Loaded: `InstrD=instr`, `PCPlus8D=pc+8`, `ValidD=1`. Bubble: `InstrD=0`, `ValidD=0`, `PCPlus8D` unchanged.
- Live response not consumed by decode (stalled or FIFO non-empty) pushes to FIFO tail. Credit rule guarantees no overflow; overflow is a design error (assertion).
- `StallD=1`: IF/ID register holds; FIFO may fill; issue stops when `count + outstanding == 2`.
- `FlushD=1` (without branch): `ValidD<=0`, `InstrD<=0`; FIFO and fetch unaffected; FlushD overrides StallD.
- `BranchTakenE=1`: `fetch_pc <= {BranchTargetE[31:2],2'b00}`; FIFO cleared; `drop_cnt <= outstanding - imem_rvalid` (responses still owed to old path); response arriving this cycle discarded; IF/ID flushed as above; no request this cycle. Branch overrides StallD, FlushD and any concurrent push/pop.
- Branch while `drop_cnt != 0`: `drop_cnt` recomputed by the same formula (covers all pending responses).
- Address arithmetic modulo 2^32; `fetch_pc` wraps 0xFFFF_FFFC → 0.

## Timing
- Reset values: `fetch_pc=RESET_PC`, `count=0`, `outstanding=0`, `drop_cnt=0`, `InstrD=0`, `PCPlus8D=0`, `ValidD=0`, `imem_req=0` while `reset` high.
- Reset mid-operation: all state returns to reset values at the edge; responses arriving after reset release whose requests preceded reset are not tracked — memory model must also be reset together.
- Latency: grant in cycle t, rvalid in t+1, decode not stalled → `ValidD=1` with that instruction in cycle t+2.
- Throughput: 1 instruction/cycle with 1-cycle memory latency and `imem_gnt=1`.
- Redirect: branch in cycle t → `imem_req` with target address in t+1; first target instruction in `InstrD` at t+3 (1-cycle memory).

## Test plan
- Reset: hold `reset` 2 cycles with `RESET_PC=0x100` → `imem_req=0`, `ValidD=0`, `InstrD=0`; first request after release has `imem_addr=0x100`.
- Streaming: gnt=1, 1-cycle memory returning `0xE3A00000+addr` → `imem_addr` 0,4,8,…; `InstrD` sequence one per cycle from third cycle, `PCPlus8D` 8,12,16.
- Stall: assert `StallD` 4 cycles mid-stream → `InstrD` held, `imem_req` drops after 2 outstanding/buffered; after release, next two instructions in order, none lost or duplicated.
- Branch with in-flight drop: 3-cycle memory latency, 2 outstanding, `BranchTakenE=1`, `BranchTargetE=0x203` → both old responses discarded, next request `0x200`, `ValidD=0` until target word arrives, then `PCPlus8D=0x208`.
- Simultaneous events: `BranchTakenE`, `imem_rvalid`, `StallD`, `FlushD` all high one cycle → response dropped, FIFO empty, `ValidD=0`, `drop_cnt = outstanding-1`.
- Wrap and reset mid-stream: `RESET_PC=0xFFFFFFF8` → addresses FFFFFFF8, FFFFFFFC, 0; assert `reset` while 2 outstanding → all outputs at reset values next cycle.

Source files
------------

// File: rtl/arm_fetch_stage_if.sv
// Instruction-memory request/response channel between the fetch stage and imem.
interface arm_fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata
  );
endinterface

// File: rtl/arm_fetch_stage.sv
// Fetch stage and IF/ID register: issues pipelined imem requests under a 2-slot
// credit, buffers returned words in a 2-entry queue and feeds decode one per cycle.
module arm_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  arm_fetch_stage_if.master imem,
  input  logic              StallD,
  input  logic              FlushD,
  input  logic              BranchTakenE,
  input  logic [31:0]       BranchTargetE,
  output logic [31:0]       InstrD,
  output logic [31:0]       PCPlus8D,
  output logic              ValidD
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  logic [31:0]  fetch_pc_q, fetch_pc_d;
  fetch_entry_t fifo_q [2];
  fetch_entry_t fifo_d [2];
  logic [1:0]   count_q, count_d;
  logic [31:0]  tag_pc_q [2];
  logic [31:0]  tag_pc_d [2];
  logic [1:0]   outstanding_q, outstanding_d;
  logic [1:0]   drop_cnt_q, drop_cnt_d;
  logic [31:0]  ifid_instr_q, ifid_instr_d;
  logic [31:0]  ifid_pc8_q, ifid_pc8_d;
  logic         ifid_valid_q, ifid_valid_d;

  logic [2:0]   credit_used;
  logic         grant;
  logic         resp_live;
  logic         pop;
  logic         bypass;
  logic         push;
  fetch_entry_t resp_entry;

  // Buffered words plus words still owed by memory may never exceed the queue depth.
  always_comb begin
    credit_used    = {1'b0, count_q} + {1'b0, outstanding_q};
    imem.imem_req  = !reset && !BranchTakenE && (credit_used < 3'd2);
    imem.imem_addr = fetch_pc_q;
    grant          = imem.imem_req && imem.imem_gnt;
    resp_live      = imem.imem_rvalid && (drop_cnt_q == 2'd0) && !BranchTakenE;
    resp_entry     = {tag_pc_q[0], imem.imem_rdata};
    pop            = !StallD && !FlushD && (count_q != 2'd0);
    bypass         = !StallD && !FlushD && (count_q == 2'd0) && resp_live;
    push           = resp_live && !bypass;
  end

  // NOTE: every next-state variable takes its current value first, so no path
  // through this block can leave one unassigned and infer a latch.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    fifo_d        = fifo_q;
    count_d       = count_q;
    tag_pc_d      = tag_pc_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    ifid_instr_d  = ifid_instr_q;
    ifid_pc8_d    = ifid_pc8_q;
    ifid_valid_d  = ifid_valid_q;

    // The pc tag queue mirrors memory order; responses retire the head even when dropped.
    if (imem.imem_rvalid) begin
      tag_pc_d[0]   = tag_pc_q[1];
      outstanding_d = outstanding_q - 2'd1;
      if (drop_cnt_q != 2'd0) drop_cnt_d = drop_cnt_q - 2'd1;
    end
    if (grant) begin
      tag_pc_d[outstanding_d[0]] = fetch_pc_q;
      outstanding_d              = outstanding_d + 2'd1;
      fetch_pc_d                 = fetch_pc_q + 32'd4;
    end

    if (pop) begin
      fifo_d[0] = fifo_q[1];
      count_d   = count_q - 2'd1;
    end
    if (push) begin
      fifo_d[count_d[0]] = resp_entry;
      count_d            = count_d + 2'd1;
    end

    if (FlushD) begin
      ifid_valid_d = 1'b0;
      ifid_instr_d = '0;
    end else if (!StallD) begin
      if (pop) begin
        ifid_valid_d = 1'b1;
        ifid_instr_d = fifo_q[0].instr;
        ifid_pc8_d   = fifo_q[0].pc + 32'd8;
      end else if (bypass) begin
        ifid_valid_d = 1'b1;
        ifid_instr_d = resp_entry.instr;
        ifid_pc8_d   = resp_entry.pc + 32'd8;
      end else begin
        ifid_valid_d = 1'b0;
        ifid_instr_d = '0;
      end
    end

    // A redirect wins over everything: every word still owed belongs to the old path.
    if (BranchTakenE) begin
      fetch_pc_d   = BranchTargetE & ~32'h3;
      count_d      = '0;
      drop_cnt_d   = outstanding_q - {1'b0, imem.imem_rvalid};
      ifid_valid_d = 1'b0;
      ifid_instr_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      ifid_instr_q  <= '0;
      ifid_pc8_q    <= '0;
      ifid_valid_q  <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      ifid_instr_q  <= ifid_instr_d;
      ifid_pc8_q    <= ifid_pc8_d;
      ifid_valid_q  <= ifid_valid_d;
    end
  end

  // NOTE: queue and tag storage carry no reset; count_q and outstanding_q
  // qualify every entry, so stale contents are never observed.
  always_ff @(posedge clk) begin
    fifo_q   <= fifo_d;
    tag_pc_q <= tag_pc_d;
  end

  assign InstrD   = ifid_instr_q;
  assign PCPlus8D = ifid_pc8_q;
  assign ValidD   = ifid_valid_q;

  a_no_fifo_overflow : assert property (@(posedge clk) disable iff (reset)
    !(push && !pop && (count_q == 2'd2)));

  a_no_spurious_response : assert property (@(posedge clk) disable iff (reset)
    !(imem.imem_rvalid && (outstanding_q == 2'd0)));

endmodule

// File: tb/tb_arm_fetch_stage.sv
// Directed table-driven bench for arm_fetch_stage: three instances with different
// reset PCs, each fed by an in-order instruction memory of configurable latency.
module tb_arm_fetch_stage;
  localparam int          NDUT = 3;
  localparam logic [31:0] OP   = 32'hE3A0_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall_d = 1'b0;
  logic        flush_d = 1'b0;
  logic        branch_e = 1'b0;
  logic [31:0] target_e = '0;
  int          mem_lat = 1;

  logic        req_w   [NDUT];
  logic [31:0] addr_w  [NDUT];
  logic [31:0] instr_w [NDUT];
  logic [31:0] pc8_w   [NDUT];
  logic        valid_w [NDUT];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam logic [31:0] RPC = (g == 0) ? 32'h0000_0000 :
                                  (g == 1) ? 32'h0000_0100 : 32'hFFFF_FFF8;
    arm_fetch_stage_if bus ();

    logic [31:0] pend_addr [4];
    int          pend_due  [4];
    int          cyc;
    logic [2:0]  wr_ptr;
    logic [2:0]  rd_ptr;

    arm_fetch_stage #(.RESET_PC(RPC)) u_dut (
      .clk           (clk),
      .reset         (reset),
      .imem          (bus),
      .StallD        (stall_d),
      .FlushD        (flush_d),
      .BranchTakenE  (branch_e),
      .BranchTargetE (target_e),
      .InstrD        (instr_w[g]),
      .PCPlus8D      (pc8_w[g]),
      .ValidD        (valid_w[g])
    );

    // In-order memory: a word granted in cycle t returns in cycle t + mem_lat.
    assign bus.imem_gnt    = 1'b1;
    assign bus.imem_rvalid = !reset && (wr_ptr != rd_ptr) && (pend_due[rd_ptr[1:0]] <= cyc);
    assign bus.imem_rdata  = OP + pend_addr[rd_ptr[1:0]];
    assign req_w[g]        = bus.imem_req;
    assign addr_w[g]       = bus.imem_addr;

    always @(posedge clk) begin
      if (reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cyc    <= 0;
      end else begin
        if (bus.imem_rvalid) rd_ptr <= rd_ptr + 3'd1;
        if (bus.imem_req && bus.imem_gnt) begin
          pend_addr[wr_ptr[1:0]] <= bus.imem_addr;
          pend_due[wr_ptr[1:0]]  <= cyc + mem_lat;
          wr_ptr                 <= wr_ptr + 3'd1;
        end
        cyc <= cyc + 1;
      end
    end
  end

  typedef struct {
    int          dut;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        br;
    logic [31:0] tgt;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc8;
  } vec_t;

  vec_t vecs [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic add(input int dut, input logic rst, stall, flush, br, input logic [31:0] tgt,
                     input logic req, input logic [31:0] addr, input logic valid,
                     input logic [31:0] instr, pc8);
    vec_t v;
    v.dut = dut; v.rst = rst; v.stall = stall; v.flush = flush; v.br = br; v.tgt = tgt;
    v.exp_req = req; v.exp_addr = addr; v.exp_valid = valid;
    v.exp_instr = instr; v.exp_pc8 = pc8;
    vecs.push_back(v);
  endtask

  // Two reset cycles; all instances must show reset outputs during the second.
  task automatic do_reset(input int lat);
    @(posedge clk); #1;
    reset = 1'b1; stall_d = 1'b0; flush_d = 1'b0; branch_e = 1'b0; target_e = '0;
    mem_lat = lat;
    @(posedge clk); #1;
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("reset_req d%0d", d),   32'(req_w[d]),   32'd0);
      check($sformatf("reset_valid d%0d", d), 32'(valid_w[d]), 32'd0);
      check($sformatf("reset_instr d%0d", d), instr_w[d],      32'd0);
      check($sformatf("reset_pc8 d%0d", d),   pc8_w[d],        32'd0);
    end
  endtask

  // One table row per cycle: drive just after the edge, sample mid-cycle.
  task automatic run_rows(input int first, input int last, input bit side);
    for (int i = first; i <= last; i++) begin
      vec_t v;
      int   d;
      v = vecs[i];
      d = v.dut;
      @(posedge clk); #1;
      reset = v.rst; stall_d = v.stall; flush_d = v.flush; branch_e = v.br; target_e = v.tgt;
      @(negedge clk);
      check($sformatf("row%0d req", i),   32'(req_w[d]),   32'(v.exp_req));
      check($sformatf("row%0d addr", i),  addr_w[d],       v.exp_addr);
      check($sformatf("row%0d valid", i), 32'(valid_w[d]), 32'(v.exp_valid));
      check($sformatf("row%0d instr", i), instr_w[d],      v.exp_instr);
      check($sformatf("row%0d pc8", i),   pc8_w[d],        v.exp_pc8);
      if (side && (i - first) < 3) begin
        check($sformatf("row%0d d1_req", i),  32'(req_w[1]), 32'd1);
        check($sformatf("row%0d d1_addr", i), addr_w[1], 32'h0000_0100 + 32'(4 * (i - first)));
        check($sformatf("row%0d wrap_addr", i), addr_w[2], 32'hFFFF_FFF8 + 32'(4 * (i - first)));
      end
    end
  endtask

  initial begin
    int a_lo, a_hi, b_lo, b_hi, c_lo, c_hi;

    // Streaming, 4-cycle stall, then a lone flush (1-cycle memory, instance 0).
    a_lo = vecs.size();
    add(0, 0, 0, 0, 0, 0, 1, 32'h00, 0, 32'h0,      32'h00);
    add(0, 0, 0, 0, 0, 0, 1, 32'h04, 0, 32'h0,      32'h00);
    add(0, 0, 0, 0, 0, 0, 1, 32'h08, 1, OP + 32'h00, 32'h08);
    add(0, 0, 0, 0, 0, 0, 1, 32'h0C, 1, OP + 32'h04, 32'h0C);
    add(0, 0, 0, 0, 0, 0, 1, 32'h10, 1, OP + 32'h08, 32'h10);
    add(0, 0, 1, 0, 0, 0, 1, 32'h14, 1, OP + 32'h0C, 32'h14);
    add(0, 0, 1, 0, 0, 0, 0, 32'h18, 1, OP + 32'h0C, 32'h14);
    add(0, 0, 1, 0, 0, 0, 0, 32'h18, 1, OP + 32'h0C, 32'h14);
    add(0, 0, 1, 0, 0, 0, 0, 32'h18, 1, OP + 32'h0C, 32'h14);
    add(0, 0, 0, 0, 0, 0, 0, 32'h18, 1, OP + 32'h0C, 32'h14);
    add(0, 0, 0, 0, 0, 0, 1, 32'h18, 1, OP + 32'h10, 32'h18);
    add(0, 0, 0, 0, 0, 0, 1, 32'h1C, 1, OP + 32'h14, 32'h1C);
    add(0, 0, 0, 0, 0, 0, 1, 32'h20, 1, OP + 32'h18, 32'h20);
    add(0, 0, 0, 1, 0, 0, 1, 32'h24, 1, OP + 32'h1C, 32'h24);
    add(0, 0, 0, 0, 0, 0, 0, 32'h28, 0, 32'h0,       32'h24);
    add(0, 0, 0, 0, 0, 0, 1, 32'h28, 1, OP + 32'h20, 32'h28);
    add(0, 0, 0, 0, 0, 0, 1, 32'h2C, 1, OP + 32'h24, 32'h2C);
    add(0, 0, 0, 0, 0, 0, 1, 32'h30, 1, OP + 32'h28, 32'h30);
    a_hi = vecs.size() - 1;

    // Branch with two words in flight, then branch+rvalid+stall+flush together (3-cycle memory).
    b_lo = vecs.size();
    add(0, 0, 0, 0, 0, 0,          1, 32'h000, 0, 32'h0,        32'h000);
    add(0, 0, 0, 0, 0, 0,          1, 32'h004, 0, 32'h0,        32'h000);
    add(0, 0, 0, 0, 1, 32'h203,    0, 32'h008, 0, 32'h0,        32'h000);
    add(0, 0, 0, 0, 0, 0,          0, 32'h200, 0, 32'h0,        32'h000);
    add(0, 0, 0, 0, 0, 0,          1, 32'h200, 0, 32'h0,        32'h000);
    add(0, 0, 0, 0, 0, 0,          1, 32'h204, 0, 32'h0,        32'h000);
    add(0, 0, 0, 0, 0, 0,          0, 32'h208, 0, 32'h0,        32'h000);
    add(0, 0, 0, 0, 0, 0,          0, 32'h208, 0, 32'h0,        32'h000);
    add(0, 0, 0, 0, 0, 0,          1, 32'h208, 1, OP + 32'h200, 32'h208);
    add(0, 0, 0, 0, 0, 0,          1, 32'h20C, 1, OP + 32'h204, 32'h20C);
    add(0, 0, 0, 0, 0, 0,          0, 32'h210, 0, 32'h0,        32'h20C);
    add(0, 0, 1, 1, 1, 32'h300,    0, 32'h210, 0, 32'h0,        32'h20C);
    add(0, 0, 0, 0, 0, 0,          1, 32'h300, 0, 32'h0,        32'h20C);
    add(0, 0, 0, 0, 0, 0,          1, 32'h304, 0, 32'h0,        32'h20C);
    add(0, 0, 0, 0, 0, 0,          0, 32'h308, 0, 32'h0,        32'h20C);
    add(0, 0, 0, 0, 0, 0,          0, 32'h308, 0, 32'h0,        32'h20C);
    add(0, 0, 0, 0, 0, 0,          1, 32'h308, 1, OP + 32'h300, 32'h308);
    b_hi = vecs.size() - 1;

    // Address wrap and reset with two outstanding (instance 2, 3-cycle memory).
    c_lo = vecs.size();
    add(2, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFF8, 0, 32'h0,        32'h0);
    add(2, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0,        32'h0);
    add(2, 1, 0, 0, 0, 0, 0, 32'h0000_0000, 0, 32'h0,        32'h0);
    add(2, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFF8, 0, 32'h0,        32'h0);
    add(2, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0,        32'h0);
    add(2, 0, 0, 0, 0, 0, 0, 32'h0000_0000, 0, 32'h0,        32'h0);
    add(2, 0, 0, 0, 0, 0, 0, 32'h0000_0000, 0, 32'h0,        32'h0);
    add(2, 0, 0, 0, 0, 0, 1, 32'h0000_0000, 1, 32'hE39F_FFF8, 32'h0);
    add(2, 0, 0, 0, 0, 0, 1, 32'h0000_0004, 1, 32'hE39F_FFFC, 32'h4);
    c_hi = vecs.size() - 1;

    do_reset(1);
    run_rows(a_lo, a_hi, 1'b1);
    do_reset(3);
    run_rows(b_lo, b_hi, 1'b0);
    do_reset(3);
    run_rows(c_lo, c_hi, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
